// File: rtl/tilelink_arbiter_pkg.sv
// tilelink_arbiter_pkg
//   TileLink-UL channel structs, opcode constants and the arbiter state
//   enum shared by the 2:1 arbiter, its round-robin picker and the bench.
//   tilelink_a is 80 bits, tilelink_d is 47 bits.
package tilelink_arbiter_pkg;

  // A-channel opcodes
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_ready;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [1:0]  d_source;
    logic [2:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_ready;
  } tilelink_d;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } arb_state;

  // Host index as it appears on the source-id fields.
  function automatic logic [1:0] src_of(input logic idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/tilelink_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin pick. A lone requester always wins; when both
//   request, the one named by prio wins.
//   req   in  2  request per host
//   prio  in  1  host favoured on a tie
//   grant out 2  one-hot grant (all zero when nobody requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  assign grant[0] = req[0] && (!req[1] || !prio);
  assign grant[1] = req[1] && (!req[0] ||  prio);

endmodule

// File: rtl/tilelink_arbiter.sv
// tilelink_arbiter
//   2:1 TileLink-UL arbiter: two hosts share one device port, one
//   transaction at a time. Round-robin A grant, A beat registered and
//   reissued with a_source = host index, D beat steered back to the owner,
//   watchdog ends a hung transaction with a synthesized error AccessAck.
//   clock, rst_n           clock and async active-low reset
//   h0_a/h1_a, *_a_ready   host A channels in, per-host accept out
//   h0_d/h1_d, *_d_ready   host D channels out, per-host ready in
//   dev_a, dev_a_ready     device A channel out, device accept in
//   dev_d, dev_d_ready     device D channel in, arbiter accept out
//   busy, owner            transaction in flight, current grant holder
//   timeout, src_mismatch  single-cycle event pulses
module tilelink_arbiter
  import tilelink_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      clock,
  input  logic      rst_n,
  input  tilelink_a h0_a,
  output logic      h0_a_ready,
  output tilelink_d h0_d,
  input  logic      h0_d_ready,
  input  tilelink_a h1_a,
  output logic      h1_a_ready,
  output tilelink_d h1_d,
  input  logic      h1_d_ready,
  output tilelink_a dev_a,
  input  logic      dev_a_ready,
  input  tilelink_d dev_d,
  output logic      dev_d_ready,
  output logic      busy,
  output logic      owner,
  output logic      timeout,
  output logic      src_mismatch
);

  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam bit         WDOG_EN    = (TIMEOUT_CYCLES != 0);

  arb_state   state;
  logic       prio;
  tilelink_a  a_reg;
  logic [7:0] wdog;

  logic [1:0] req;
  logic [1:0] grant;
  logic       winner;
  logic       accept;
  tilelink_a  win_a;
  logic       owner_d_ready;
  logic       d_fire;
  logic       wdog_hit;
  logic       fire;
  tilelink_d  resp_d;
  logic       unused_fields;

  assign unused_fields = ^{h0_a.a_ready, h1_a.a_ready, dev_d.d_ready};

  assign req = {h1_a.a_valid, h0_a.a_valid};

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .prio  (prio),
    .grant (grant)
  );

  assign winner        = grant[1];
  // Gating with rst_n keeps a_ready low while reset is held.
  assign accept        = rst_n && (state == IDLE) && (|grant);
  assign win_a         = winner ? h1_a : h0_a;
  assign owner_d_ready = owner ? h1_d_ready : h0_d_ready;
  assign d_fire        = (state == RESP) && dev_d.d_valid && owner_d_ready;
  assign wdog_hit      = WDOG_EN && (wdog == WDOG_LIMIT) &&
                         ((state == REQ) || (state == RESP));
  // A completing beat beats the watchdog on the same cycle.
  assign fire          = wdog_hit && !d_fire;

  assign timeout      = fire;
  assign src_mismatch = d_fire && (dev_d.d_source != src_of(owner));
  assign busy         = (state != IDLE);
  assign h0_a_ready   = accept && !winner;
  assign h1_a_ready   = accept &&  winner;

  always_comb begin
    dev_a       = '0;
    resp_d      = '0;
    dev_d_ready = 1'b0;
    h0_d        = '0;
    h1_d        = '0;
    case (state)
      REQ: begin
        dev_a         = a_reg;
        dev_a.a_valid = 1'b1;
        dev_a.a_ready = 1'b0;
      end
      RESP: begin
        resp_d         = dev_d;
        resp_d.d_ready = 1'b0;
        dev_d_ready    = owner_d_ready;
      end
      ABORT: begin
        // Late device beats are sunk while the host gets the error ack.
        resp_d.d_valid  = 1'b1;
        resp_d.d_opcode = TL_ACCESS_ACK;
        resp_d.d_size   = a_reg.a_size;
        resp_d.d_source = src_of(owner);
        resp_d.d_error  = 1'b1;
        dev_d_ready     = 1'b1;
      end
      default: ;
    endcase
    if (owner) h1_d = resp_d;
    else       h0_d = resp_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      a_reg <= '0;
      wdog  <= '0;
    end else begin
      if ((state == REQ || state == RESP) && wdog != 8'hFF)
        wdog <= wdog + 8'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg          <= win_a;
            a_reg.a_source <= src_of(winner);
            a_reg.a_ready  <= 1'b0;
            owner          <= winner;
            prio           <= ~winner;
            wdog           <= '0;
            state          <= REQ;
          end
        end
        REQ: begin
          if (fire)             state <= ABORT;
          else if (dev_a_ready) state <= RESP;
        end
        RESP: begin
          if (d_fire)    state <= IDLE;
          else if (fire) state <= ABORT;
        end
        ABORT: begin
          if (owner_d_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilelink_arbiter.sv
// tb_tilelink_arbiter
//   Scenario bench for the 2:1 TileLink-UL arbiter. Expected device A beats
//   and host D beats are queued when stimulus is driven and compared by a
//   negedge monitor when the DUT hands them over; each scenario task also
//   does its own inline checks. Inputs change 1ns after posedge, outputs
//   are sampled on negedge.
module tb_tilelink_arbiter;
  import tilelink_arbiter_pkg::*;

  logic      clock = 1'b0;
  logic      rst_n;
  tilelink_a h0_a, h1_a, dev_a;
  tilelink_d h0_d, h1_d, dev_d;
  logic      h0_a_ready, h1_a_ready, h0_d_ready, h1_d_ready;
  logic      dev_a_ready, dev_d_ready;
  logic      busy, owner, timeout, src_mismatch;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  src;
    logic [31:0] data;
  } exp_a_t;

  typedef struct {
    logic        host;
    logic [2:0]  op;
    logic [1:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_d_t;

  exp_a_t exp_a_q[$];
  exp_d_t exp_d_q[$];

  always #5 clock = ~clock;

  tilelink_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .h0_a         (h0_a),
    .h0_a_ready   (h0_a_ready),
    .h0_d         (h0_d),
    .h0_d_ready   (h0_d_ready),
    .h1_a         (h1_a),
    .h1_a_ready   (h1_a_ready),
    .h1_d         (h1_d),
    .h1_d_ready   (h1_d_ready),
    .dev_a        (dev_a),
    .dev_a_ready  (dev_a_ready),
    .dev_d        (dev_d),
    .dev_d_ready  (dev_d_ready),
    .busy         (busy),
    .owner        (owner),
    .timeout      (timeout),
    .src_mismatch (src_mismatch)
  );

  function automatic tilelink_a mk_a(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [31:0] data);
    tilelink_a b;
    b           = '0;
    b.a_valid   = 1'b1;
    b.a_opcode  = op;
    b.a_size    = 2'd2;
    b.a_source  = 2'd3;   // junk the arbiter must overwrite
    b.a_address = addr;
    b.a_mask    = 4'hF;
    b.a_data    = data;
    b.a_ready   = 1'b1;   // ignored field
    return b;
  endfunction

  function automatic tilelink_d mk_d(input logic [2:0] op, input logic [1:0] src,
                                     input logic [31:0] data);
    tilelink_d b;
    b          = '0;
    b.d_valid  = 1'b1;
    b.d_opcode = op;
    b.d_size   = 2'd2;
    b.d_source = src;
    b.d_sink   = 3'd5;
    b.d_data   = data;
    b.d_ready  = 1'b1;    // ignored field
    return b;
  endfunction

  // Scoreboard monitor
  always @(negedge clock) begin : monitor
    exp_a_t    ea;
    exp_d_t    ed;
    tilelink_d cur;
    logic      rdy;
    if (rst_n && dev_a.a_valid && dev_a_ready) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        $display("FAIL dev_a_unexpected: got addr=%h, no beat expected", dev_a.a_address);
      end else begin
        ea = exp_a_q.pop_front();
        if ({dev_a.a_opcode, dev_a.a_address, dev_a.a_source, dev_a.a_data} !==
            {ea.op, ea.addr, ea.src, ea.data})
          $display("FAIL dev_a_beat: got op=%0d addr=%h src=%0d data=%h, want op=%0d addr=%h src=%0d data=%h",
                   dev_a.a_opcode, dev_a.a_address, dev_a.a_source, dev_a.a_data,
                   ea.op, ea.addr, ea.src, ea.data);
        else passed++;
      end
    end
    for (int h = 0; h < 2; h++) begin
      cur = (h == 1) ? h1_d : h0_d;
      rdy = (h == 1) ? h1_d_ready : h0_d_ready;
      if (cur.d_valid && rdy) begin
        checks++;
        if (exp_d_q.size() == 0) begin
          $display("FAIL host_d_unexpected: host %0d got data=%h, no beat expected", h, cur.d_data);
        end else begin
          ed = exp_d_q.pop_front();
          if ({1'(h), cur.d_opcode, cur.d_source, cur.d_data, cur.d_error} !==
              {ed.host, ed.op, ed.src, ed.data, ed.err})
            $display("FAIL host_d_beat: got host=%0d op=%0d src=%0d data=%h err=%0d, want host=%0d op=%0d src=%0d data=%h err=%0d",
                     h, cur.d_opcode, cur.d_source, cur.d_data, cur.d_error,
                     ed.host, ed.op, ed.src, ed.data, ed.err);
          else passed++;
        end
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  task automatic do_reset;
    h0_a = '0; h1_a = '0; dev_d = '0;
    dev_a_ready = 1'b0; h0_d_ready = 1'b1; h1_d_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    // Requests and a device beat present during reset must not leak through.
    h0_a = mk_a(TL_GET, 32'h10, 32'h0);
    h1_a = mk_a(TL_GET, 32'h20, 32'h0);
    dev_d = mk_d(TL_ACCESS_ACK_DATA, 2'd0, 32'h55);
    dev_a_ready = 1'b1; h0_d_ready = 1'b1; h1_d_ready = 1'b1;
    rst_n = 1'b0;
    sample;
    checks++;
    if ({busy, owner, timeout, src_mismatch, h0_a_ready, h1_a_ready, dev_d_ready} !== 7'b0)
      $display("FAIL reset_ctrl: got %b, want 0000000",
               {busy, owner, timeout, src_mismatch, h0_a_ready, h1_a_ready, dev_d_ready});
    else passed++;
    checks++;
    if (dev_a !== '0) $display("FAIL reset_dev_a: got %h, want 0", dev_a);
    else passed++;
    checks++;
    if (h0_d !== '0 || h1_d !== '0) $display("FAIL reset_host_d: got %h %h, want 0 0", h0_d, h1_d);
    else passed++;
    h0_a = '0; h1_a = '0; dev_d = '0; dev_a_ready = 1'b0;
    step;
    rst_n = 1'b1;
    sample;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b, want 0", busy);
    else passed++;
  endtask

  task automatic test_single_get;
    step;
    exp_a_q.push_back('{TL_GET, 32'h1000, 2'd0, 32'h0});
    dev_a_ready = 1'b1;
    h0_a = mk_a(TL_GET, 32'h1000, 32'h0);
    sample;
    checks++;
    if ({h1_a_ready, h0_a_ready} !== 2'b01) $display("FAIL t1_a_ready: got %b, want 01", {h1_a_ready, h0_a_ready});
    else passed++;
    checks++;
    if (dev_a.a_valid !== 1'b0) $display("FAIL t1_early_dev_a: got %b, want 0", dev_a.a_valid);
    else passed++;
    step;
    h0_a = '0;
    sample;
    checks++;
    if ({dev_a.a_valid, dev_a.a_source, busy} !== {1'b1, 2'd0, 1'b1})
      $display("FAIL t1_dev_a_latency: got valid=%b src=%0d busy=%b, want 1 0 1",
               dev_a.a_valid, dev_a.a_source, busy);
    else passed++;
    step;
    exp_d_q.push_back('{1'b0, TL_ACCESS_ACK_DATA, 2'd0, 32'hCAFEF00D, 1'b0});
    dev_d = mk_d(TL_ACCESS_ACK_DATA, 2'd0, 32'hCAFEF00D);
    sample;
    checks++;
    if ({h0_d.d_valid, h0_d.d_data, h1_d.d_valid, src_mismatch, dev_d_ready} !==
        {1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1})
      $display("FAIL t1_response: got v0=%b data=%h v1=%b mism=%b dready=%b, want 1 cafef00d 0 0 1",
               h0_d.d_valid, h0_d.d_data, h1_d.d_valid, src_mismatch, dev_d_ready);
    else passed++;
    step;
    dev_d = '0; dev_a_ready = 1'b0;
    sample;
    checks++;
    if (busy !== 1'b0) $display("FAIL t1_idle: busy got %b, want 0", busy);
    else passed++;
  endtask

  task automatic test_fairness;
    logic w;
    int   n0, n1;
    do_reset;
    n0 = 0; n1 = 0;
    h0_a = mk_a(TL_GET, 32'h2000, 32'h0);
    h1_a = mk_a(TL_PUT_FULL, 32'h3000, 32'hA0);
    dev_a_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = i[0];
      exp_a_q.push_back('{w ? TL_PUT_FULL : TL_GET,
                          w ? h1_a.a_address : h0_a.a_address,
                          {1'b0, w},
                          w ? h1_a.a_data : h0_a.a_data});
      exp_d_q.push_back('{w, TL_ACCESS_ACK, {1'b0, w}, 32'h0, 1'b0});
      sample;
      checks++;
      if ({h1_a_ready, h0_a_ready} !== (w ? 2'b10 : 2'b01))
        $display("FAIL t2_grant_%0d: got %b, want %b", i, {h1_a_ready, h0_a_ready}, w ? 2'b10 : 2'b01);
      else passed++;
      step;
      if (w) begin
        n1++;
        h1_a = mk_a(TL_PUT_FULL, 32'h3000 + n1 * 16, 32'hA0 + n1);
      end else begin
        n0++;
        h0_a = mk_a(TL_GET, 32'h2000 + n0 * 16, 32'h0);
      end
      sample;
      checks++;
      if (owner !== w) $display("FAIL t2_owner_%0d: got %b, want %b", i, owner, w);
      else passed++;
      step;
      dev_d = mk_d(TL_ACCESS_ACK, {1'b0, w}, 32'h0);
      sample;
      checks++;
      if ({h1_a_ready, h0_a_ready} !== 2'b00)
        $display("FAIL t2_resp_accept_%0d: got %b, want 00", i, {h1_a_ready, h0_a_ready});
      else passed++;
      step;
      dev_d = '0;
    end
    h0_a = '0; h1_a = '0; dev_a_ready = 1'b0;
  endtask

  task automatic test_stall;
    int pulses;
    step;
    pulses = 0;
    exp_a_q.push_back('{TL_PUT_FULL, 32'h4000, 2'd1, 32'h12345678});
    exp_d_q.push_back('{1'b1, TL_ACCESS_ACK, 2'd1, 32'h0, 1'b0});
    h1_a = mk_a(TL_PUT_FULL, 32'h4000, 32'h12345678);
    dev_a_ready = 1'b0;
    sample;
    if (h1_a_ready) pulses++;
    step;
    // Host moves on to another beat; the registered one must not change.
    h1_a = mk_a(TL_GET, 32'h9999, 32'h0);
    for (int c = 0; c < 5; c++) begin
      sample;
      if (h1_a_ready) pulses++;
      checks++;
      if ({dev_a.a_valid, dev_a.a_opcode, dev_a.a_address, dev_a.a_source, dev_a.a_data} !==
          {1'b1, TL_PUT_FULL, 32'h4000, 2'd1, 32'h12345678})
        $display("FAIL t3_stable_%0d: got v=%b op=%0d addr=%h src=%0d data=%h, want 1 0 4000 1 12345678",
                 c, dev_a.a_valid, dev_a.a_opcode, dev_a.a_address, dev_a.a_source, dev_a.a_data);
      else passed++;
      step;
    end
    dev_a_ready = 1'b1;
    sample;
    if (h1_a_ready) pulses++;
    step;
    h1_a = '0; dev_a_ready = 1'b0;
    dev_d = mk_d(TL_ACCESS_ACK, 2'd1, 32'h0);
    sample;
    if (h1_a_ready) pulses++;
    checks++;
    if ({h1_d.d_valid, h0_d.d_valid} !== 2'b10)
      $display("FAIL t3_steer: got v1=%b v0=%b, want 1 0", h1_d.d_valid, h0_d.d_valid);
    else passed++;
    step;
    dev_d = '0;
    checks++;
    if (pulses !== 1) $display("FAIL t3_ready_pulses: got %0d, want 1", pulses);
    else passed++;
  endtask

  task automatic test_timeout;
    step;
    exp_a_q.push_back('{TL_GET, 32'h5000, 2'd0, 32'h0});
    h0_a = mk_a(TL_GET, 32'h5000, 32'h0);
    dev_a_ready = 1'b1; h0_d_ready = 1'b0;
    sample;
    step;
    h0_a = '0;
    for (int k = 0; k < 8; k++) begin
      sample;
      checks++;
      if (timeout !== 1'b0) $display("FAIL t4_early_timeout_%0d: got %b, want 0", k, timeout);
      else passed++;
      step;
    end
    sample;
    checks++;
    if (timeout !== 1'b1) $display("FAIL t4_timeout_pulse: got %b, want 1", timeout);
    else passed++;
    exp_d_q.push_back('{1'b0, TL_ACCESS_ACK, 2'd0, 32'h0, 1'b1});
    step;
    sample;
    checks++;
    if ({h0_d.d_valid, h0_d.d_opcode, h0_d.d_error, h0_d.d_source, h0_d.d_size} !==
        {1'b1, TL_ACCESS_ACK, 1'b1, 2'd0, 2'd2})
      $display("FAIL t4_abort_beat: got v=%b op=%0d err=%b src=%0d size=%0d, want 1 0 1 0 2",
               h0_d.d_valid, h0_d.d_opcode, h0_d.d_error, h0_d.d_source, h0_d.d_size);
    else passed++;
    checks++;
    if ({timeout, dev_d_ready, dev_a.a_valid, h1_d.d_valid} !== 4'b0100)
      $display("FAIL t4_abort_side: got %b, want 0100", {timeout, dev_d_ready, dev_a.a_valid, h1_d.d_valid});
    else passed++;
    step;
    h0_d_ready = 1'b1;
    sample;
    step;
    sample;
    checks++;
    if (busy !== 1'b0) $display("FAIL t4_back_idle: busy got %b, want 0", busy);
    else passed++;
  endtask

  task automatic test_completion_wins;
    step;
    exp_a_q.push_back('{TL_GET, 32'h6000, 2'd0, 32'h0});
    h0_a = mk_a(TL_GET, 32'h6000, 32'h0);
    dev_a_ready = 1'b1; h0_d_ready = 1'b1;
    sample;
    step;
    h0_a = '0;
    for (int k = 0; k < 8; k++) begin
      sample;
      step;
    end
    exp_d_q.push_back('{1'b0, TL_ACCESS_ACK_DATA, 2'd0, 32'h600D, 1'b0});
    dev_d = mk_d(TL_ACCESS_ACK_DATA, 2'd0, 32'h600D);
    sample;
    checks++;
    if (timeout !== 1'b0) $display("FAIL tcw_no_timeout: got %b, want 0", timeout);
    else passed++;
    step;
    dev_d = '0; dev_a_ready = 1'b0;
    sample;
    checks++;
    if ({busy, h0_d.d_valid} !== 2'b00)
      $display("FAIL tcw_idle: got busy=%b v0=%b, want 0 0", busy, h0_d.d_valid);
    else passed++;
  endtask

  task automatic test_src_mismatch;
    step;
    exp_a_q.push_back('{TL_GET, 32'h7000, 2'd0, 32'h0});
    exp_d_q.push_back('{1'b0, TL_ACCESS_ACK_DATA, 2'd1, 32'hBEEF, 1'b0});
    h0_a = mk_a(TL_GET, 32'h7000, 32'h0);
    dev_a_ready = 1'b1;
    sample;
    step;
    h0_a = '0;
    sample;
    step;
    dev_d = mk_d(TL_ACCESS_ACK_DATA, 2'd1, 32'hBEEF);
    sample;
    checks++;
    if ({src_mismatch, h0_d.d_valid, h1_d.d_valid} !== 3'b110)
      $display("FAIL t5_src_mismatch: got mism=%b v0=%b v1=%b, want 1 1 0",
               src_mismatch, h0_d.d_valid, h1_d.d_valid);
    else passed++;
    step;
    dev_d = '0; dev_a_ready = 1'b0;
    sample;
    checks++;
    if (src_mismatch !== 1'b0) $display("FAIL t5_one_cycle: got %b, want 0", src_mismatch);
    else passed++;
  endtask

  task automatic test_reset_mid_resp;
    step;
    exp_a_q.push_back('{TL_GET, 32'h8000, 2'd1, 32'h0});
    h1_a = mk_a(TL_GET, 32'h8000, 32'h0);
    dev_a_ready = 1'b1; h1_d_ready = 1'b0;
    sample;
    step;
    h1_a = '0;
    sample;
    step;
    dev_d = mk_d(TL_ACCESS_ACK_DATA, 2'd1, 32'h1111);
    sample;
    checks++;
    if ({h1_d.d_valid, owner} !== 2'b11)
      $display("FAIL t6_pre_reset: got v1=%b owner=%b, want 1 1", h1_d.d_valid, owner);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, owner, timeout, src_mismatch, dev_d_ready, h0_a_ready, h1_a_ready} !== 7'b0 ||
        dev_a !== '0 || h0_d !== '0 || h1_d !== '0)
      $display("FAIL t6_async_clear: got ctrl=%b dev_a=%h h0_d=%h h1_d=%h, want all 0",
               {busy, owner, timeout, src_mismatch, dev_d_ready, h0_a_ready, h1_a_ready},
               dev_a, h0_d, h1_d);
    else passed++;
    dev_d = '0; h1_d_ready = 1'b1;
    step;
    rst_n = 1'b1;
    exp_a_q.push_back('{TL_GET, 32'h8100, 2'd0, 32'h0});
    exp_d_q.push_back('{1'b0, TL_ACCESS_ACK, 2'd0, 32'h0, 1'b0});
    h0_a = mk_a(TL_GET, 32'h8100, 32'h0);
    h1_a = mk_a(TL_GET, 32'h8200, 32'h0);
    sample;
    checks++;
    if ({h1_a_ready, h0_a_ready} !== 2'b01)
      $display("FAIL t6_first_grant: got %b, want 01", {h1_a_ready, h0_a_ready});
    else passed++;
    step;
    h0_a = '0; h1_a = '0;
    sample;
    checks++;
    if (owner !== 1'b0) $display("FAIL t6_owner: got %b, want 0", owner);
    else passed++;
    step;
    dev_d = mk_d(TL_ACCESS_ACK, 2'd0, 32'h0);
    sample;
    step;
    dev_d = '0; dev_a_ready = 1'b0;
    sample;
    checks++;
    if (busy !== 1'b0) $display("FAIL t6_idle: busy got %b, want 0", busy);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset;
    test_single_get;
    test_fairness;
    test_stall;
    test_timeout;
    test_completion_wins;
    test_src_mismatch;
    test_reset_mid_resp;
    checks++;
    if (exp_a_q.size() != 0 || exp_d_q.size() != 0)
      $display("FAIL scoreboard_drained: got %0d A and %0d D beats left, want 0 0",
               exp_a_q.size(), exp_d_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
